fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the 2.5-stage RV64 pipeline. Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers each returned instruction with its PC into the IF/ID output that feeds decode, the immediate generator and the register file.
- Handles downstream stall with a one-entry skid buffer, and handles branch/jump redirect, including squashing a request already in flight.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value of if_instr while the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  64  byte address of the outstanding request; stable while imem_req=1 and no ack.
- imem_ack  in  1  response strobe; may arrive in the same cycle as imem_req or any later cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- stall  in  1  decode cannot accept this cycle.
- redirect  in  1  taken branch/jal/jalr from execute.
- redirect_pc  in  64  new fetch address; bits [1:0] ignored and treated as 0.
- if_valid  out  1  IF/ID entry valid.
- if_pc  out  64  PC of if_instr.
- if_instr  out  32  fetched instruction.
- if_pc_plus4  out  64  if_pc + 4, registered alongside if_pc.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, req_addr=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=NOP_INSTR, skid empty.
  - imem_req is gated to 0 while rst_n=0.
- Internal registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request; imem_addr=req_addr.
  - skid: {valid, pc, instr}.
  - 64-bit add arithmetic wraps modulo 2^64, no overflow detect.
- Consume: the IF/ID entry is consumed at a clock edge where if_valid=1 and stall=0.
- slot_free = !if_valid || !stall.
- States:
  - REQ:
    - imem_req=1.
    - On ack with slot_free: load if_*={req_addr, imem_rdata, req_addr+4}, if_valid=1, pc=req_addr+4, req_addr=req_addr+4. Stay in REQ.
    - On ack with !slot_free: capture into skid, pc=req_addr+4, go to HOLD.
    - No ack: hold all outputs.
  - HOLD:
    - imem_req=0.
    - When stall=0: move skid to if_*, if_valid=1, clear skid, req_addr=pc, go to REQ.
  - DROP:
    - Entered on redirect while a request is outstanding without ack.
    - imem_req=1; imem_addr keeps the old req_addr.
    - On ack: discard imem_rdata, req_addr=pc, go to REQ.
- Redirect has highest priority and applies at the same edge, in any state, regardless of stall:
  - if_valid=0, if_instr=NOP_INSTR, skid cleared, pc={redirect_pc[63:2],2'b00}.
  - REQ, no ack this cycle: go to DROP; req_addr unchanged.
  - REQ with ack this cycle: data discarded, req_addr=new pc, stay in REQ.
  - HOLD: req_addr=new pc, go to REQ.
  - DROP: pc updated again, stay in DROP (last redirect wins).
- Throughput and latency:
  - Zero-wait memory (ack in the same cycle as req): one instruction per cycle.
  - First if_valid=1 at the first edge after rst_n rises at which ack is seen.
  - Redirect-to-valid: 1 cycle with zero-wait memory, plus any extra cycles to drain an in-flight request.
- Invariants:
  - imem_addr never changes while imem_req=1 and ack is not yet seen.
  - No instruction is dropped or duplicated under stall.
  - At most one request outstanding.

Test Plan:
- Reset release, RESET_PC=0x1000, zero-wait memory returning addr-tagged words -> if_pc = 0x1000, 0x1004, 0x1008 on consecutive cycles; if_pc_plus4 = if_pc+4; if_valid=1 each cycle.
- Stall held 3 cycles while if_pc=0x1004 -> if_pc stays 0x1004; 0x1008 is held in skid; imem_req=0 in HOLD; after release, 0x1008 then 0x100C appear in order with no gaps or duplicates.
- Memory with 3-cycle ack latency, redirect to 0x2002 one cycle after req for 0x1008 -> imem_addr stays 0x1008 until ack; that data is discarded; next imem_addr=0x2000; if_pc=0x2000 with its instruction.
- Redirect and ack in the same cycle, target 0x3000 -> returned word not written; if_valid=0 next cycle; following request addr=0x3000.
- Redirect while in HOLD with stall=1 -> skid and if_valid cleared; stall ignored; next request at the redirect target.
- rst_n asserted mid-wait with imem_req=1 -> imem_req=0 and if_valid=0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake,
// and registers each fetched word into the IF/ID entry with a one-entry skid buffer.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc_plus4
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [63:0] if_pc_plus4_q, if_pc_plus4_d;

    logic        slot_free;
    logic        consume;
    logic [63:0] target_pc;
    logic [63:0] req_plus4;

    assign slot_free = !if_valid_q || !stall;
    assign consume   = if_valid_q && !stall;
    assign target_pc = redirect_pc & ~64'h3;
    assign req_plus4 = req_addr_q + 64'd4;

    assign imem_req    = rst_n && ((state_q == ST_REQ) || (state_q == ST_DROP));
    assign imem_addr   = req_addr_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;

        if (redirect) begin
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            skid_valid_d = 1'b0;
            pc_d         = target_pc;
            case (state_q)
                ST_REQ: begin
                    if (imem_ack) begin
                        req_addr_d = target_pc;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    // A squashed request finishing on this edge leaves nothing to drain.
                    if (imem_ack) begin
                        req_addr_d = target_pc;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    req_addr_d = target_pc;
                    state_d    = ST_REQ;
                end
            endcase
        end else begin
            // A consumed entry must not be presented again unless replaced below.
            if (consume) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
            case (state_q)
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_d = req_plus4;
                        if (slot_free) begin
                            if_valid_d    = 1'b1;
                            if_pc_d       = req_addr_q;
                            if_instr_d    = imem_rdata;
                            if_pc_plus4_d = req_plus4;
                            req_addr_d    = req_plus4;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = req_addr_q;
                            skid_instr_d = imem_rdata;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_valid_d    = 1'b1;
                        if_pc_d       = skid_pc_q;
                        if_instr_d    = skid_instr_q;
                        if_pc_plus4_d = skid_pc_q + 64'd4;
                        skid_valid_d  = 1'b0;
                        req_addr_d    = pc_q;
                        state_d       = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        req_addr_d = pc_q;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= NOP_INSTR;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a credit-limited imem model tags each word
// with its address; every consumed IF/ID entry is matched against expected PCs.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] TAG    = 32'hC0DE_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [63:0] if_pc_plus4;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned lat           = 0;
    int unsigned cnt           = 0;
    int unsigned acks_done     = 0;
    int unsigned credits_given = 0;

    logic [63:0] sb_q[$];

    logic        prev_wait = 1'b0;
    logic [63:0] prev_addr = '0;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_pc_plus4(if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    assign imem_ack   = imem_req && (acks_done < credits_given) && (cnt >= lat);
    assign imem_rdata = imem_addr[31:0] ^ TAG;

    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) cnt <= 0;
        else                                 cnt <= cnt + 1;
        if (imem_ack) acks_done <= acks_done + 1;
    end

    // Consumption is decided at the negedge from the stall value decode will present.
    always @(negedge clk) begin
        if (rst_n && if_valid && !stall) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_pc", if_pc, e);
                check("sb_instr", {32'd0, if_instr}, {32'd0, e[31:0] ^ TAG});
                check("sb_pc4", if_pc_plus4, e + 64'd4);
            end
        end
        if (rst_n && !if_valid) check("nop_when_invalid", {32'd0, if_instr}, {32'd0, NOP});
        if (rst_n && prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
        prev_wait = rst_n && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

    task automatic grant(input int unsigned n);
        credits_given = credits_given + n;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        lat           = 0;
        credits_given = acks_done;
        sb_q.delete();
        @(negedge clk);
        check("rst_valid", {63'd0, if_valid}, 64'd0);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_pc", if_pc, 64'd0);
        check("rst_pc4", if_pc_plus4, 64'd0);
        check("rst_instr", {32'd0, if_instr}, {32'd0, NOP});
        check("rst_addr", imem_addr, RST_PC);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Zero-wait streaming from reset.
        do_reset();
        grant(3);
        sb_q.push_back(64'h1000);
        sb_q.push_back(64'h1004);
        sb_q.push_back(64'h1008);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_valid", {63'd0, if_valid}, 64'd1);
            check("t1_pc", if_pc, 64'h1000 + 64'(4 * i));
        end
        wait_drain("t1_drain");

        // Stall for 3 cycles while 0x1004 is presented; 0x1008 parks in the skid.
        do_reset();
        grant(4);
        for (int i = 0; i < 4; i++) sb_q.push_back(64'h1000 + 64'(4 * i));
        @(posedge clk);
        @(posedge clk);
        #1 stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t2_hold_req", {63'd0, imem_req}, 64'd0);
        check("t2_hold_pc", if_pc, 64'h1004);
        @(posedge clk);
        @(negedge clk);
        check("t2_hold_pc2", if_pc, 64'h1004);
        @(posedge clk);
        #1 stall = 1'b0;
        wait_drain("t2_drain");

        // 3-cycle memory, redirect to a misaligned target while 0x1008 is in flight.
        do_reset();
        lat = 3;
        grant(4);
        sb_q.push_back(64'h1000);
        sb_q.push_back(64'h1004);
        sb_q.push_back(64'h2000);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (imem_req && imem_addr == 64'h1008) found = 1'b1;
            end
            check("t3_reach_1008", {63'd0, found}, 64'd1);
        end
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 64'h2002;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("t3_drop_addr", imem_addr, 64'h1008);
        check("t3_drop_valid", {63'd0, if_valid}, 64'd0);
        begin
            bit moved = 1'b0;
            for (int i = 0; i < 20 && !moved; i++) begin
                @(negedge clk);
                if (imem_req && imem_addr != 64'h1008) moved = 1'b1;
            end
            check("t3_new_addr", imem_addr, 64'h2000);
        end
        wait_drain("t3_drain");

        // Redirect coincident with an ack.
        do_reset();
        grant(2);
        sb_q.push_back(64'h1000);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 64'h3000;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("t4_valid", {63'd0, if_valid}, 64'd0);
        check("t4_addr", imem_addr, 64'h3000);
        check("t4_req", {63'd0, imem_req}, 64'd1);
        grant(1);
        sb_q.push_back(64'h3000);
        wait_drain("t4_drain");

        // Redirect while holding the skid under stall.
        do_reset();
        grant(2);
        @(posedge clk);
        #1 stall = 1'b1;
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 64'h4000;
        @(negedge clk);
        check("t5_hold_req", {63'd0, imem_req}, 64'd0);
        @(posedge clk);
        #1 redirect = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("t5_valid", {63'd0, if_valid}, 64'd0);
        check("t5_addr", imem_addr, 64'h4000);
        check("t5_req", {63'd0, imem_req}, 64'd1);
        grant(1);
        sb_q.push_back(64'h4000);
        wait_drain("t5_drain");

        // Asynchronous reset while a request is pending.
        do_reset();
        grant(1);
        stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_pre_valid", {63'd0, if_valid}, 64'd1);
        check("t6_pre_req", {63'd0, imem_req}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", {63'd0, imem_req}, 64'd0);
        check("t6_async_valid", {63'd0, if_valid}, 64'd0);
        check("t6_async_instr", {32'd0, if_instr}, {32'd0, NOP});
        do_reset();
        grant(1);
        sb_q.push_back(RST_PC);
        wait_drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", 1);
        $fatal(1);
    end

endmodule
